// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: size codes, FSM encodings, requester IDs.
package mem_pkg;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t MEM_BYTE   = 2'b00;
  localparam mem_size_t MEM_HALF   = 2'b01;
  localparam mem_size_t MEM_WORD   = 2'b10;
  localparam mem_size_t MEM_DOUBLE = 2'b11;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle  = 2'd0;
  localparam arb_state_t StIssue = 2'd1;
  localparam arb_state_t StWait  = 2'd2;
  localparam arb_state_t StResp  = 2'd3;

  // Requester IDs double as bit positions in the request/grant vectors.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-engine signals shared by the arbiter and its neighbours.
interface mem_port_arbiter_if import mem_pkg::*;;

  logic            if_req;
  logic [63:0]     if_addr;
  logic            if_ack;
  logic [63:0]     if_rdata;

  logic            d_req;
  logic            d_we;
  logic [63:0]     d_addr;
  mem_size_t       d_size;
  logic [63:0]     d_wdata;
  logic            d_ack;
  logic [63:0]     d_rdata;

  logic            mm_start;
  logic            mm_we;
  logic [63:0]     mm_addr;
  mem_size_t       mm_size;
  logic [63:0]     mm_wdata;
  logic            mm_done;
  logic [63:0]     mm_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_size, d_wdata, mm_done, mm_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mm_start, mm_we, mm_addr, mm_size, mm_wdata
  );

  // Requesters plus memory engine side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_size, d_wdata, mm_done, mm_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mm_start, mm_we, mm_addr, mm_size, mm_wdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; one-hot grant, bit index = requester ID.
module rr_arbiter2 import mem_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == REQ_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-serial memory engine between instruction fetch and data load/store,
// holding the command stable for the whole transfer and guarding it with a watchdog.
module mem_port_arbiter import mem_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter mem_size_t   IF_SIZE        = MEM_WORD
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] TimeoutMax = CntW'(TIMEOUT_CYCLES - 1);

  arb_state_t      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic            we_q, we_d;
  logic [63:0]     addr_q, addr_d;
  mem_size_t       size_q, size_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [63:0]     if_rdata_q, if_rdata_d;
  logic [63:0]     d_rdata_q, d_rdata_d;
  logic [1:0]      gnt;

  rr_arbiter2 u_rr (
    .req        ({bus.d_req, bus.if_req}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          grant_d      = gnt[REQ_D] ? REQ_D : REQ_IF;
          last_grant_d = gnt[REQ_D] ? REQ_D : REQ_IF;
          if (gnt[REQ_D]) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            size_d  = bus.d_size;
            wdata_d = bus.d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            size_d  = IF_SIZE;
            wdata_d = 64'd0;
          end
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus.mm_done) begin
          if (grant_q == REQ_IF) begin
            if_rdata_d = bus.mm_rdata;
          end else if (!we_q) begin
            d_rdata_d = bus.mm_rdata;
          end
          state_d = StResp;
        end else if (cnt_q == TimeoutMax) begin
          // Abort: the requester still gets its ack, with zeroed data.
          timeout_d = 1'b1;
          if (grant_q == REQ_IF) begin
            if_rdata_d = 64'd0;
          end else begin
            d_rdata_d = 64'd0;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= REQ_D;
      grant_q      <= REQ_IF;
      we_q         <= 1'b0;
      addr_q       <= 64'd0;
      size_q       <= MEM_BYTE;
      wdata_q      <= 64'd0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      if_rdata_q   <= 64'd0;
      d_rdata_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mm_start = (state_q == StIssue);
  assign bus.mm_we    = we_q;
  assign bus.mm_addr  = addr_q;
  assign bus.mm_size  = size_q;
  assign bus.mm_wdata = wdata_q;
  assign bus.if_ack   = (state_q == StResp) && (grant_q == REQ_IF);
  assign bus.d_ack    = (state_q == StResp) && (grant_q == REQ_D);
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign busy         = (state_q != StIdle);
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays both requesters and the memory engine.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  logic busy;
  logic timeout_err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (64),
    .IF_SIZE        (2'b10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Called at a negedge with requests already set. Plays the memory engine: asserts
  // mm_done in the n_wait-th WAIT cycle (0 = never). Cycle 1 is the IDLE cycle that
  // ends at the next posedge; returns at the negedge where the first ack is observed.
  task automatic run_xfer(input int n_wait, input logic [63:0] rd, input bit mutate,
                          input bit drop, output int ack_cyc, output int starts,
                          output int if_acks, output int d_acks, output logic [63:0] s_addr,
                          output logic [1:0] s_size, output logic s_we,
                          output logic [63:0] s_wdata, output bit unstable);
    bit in_wait = 0;
    int wc = 0;
    ack_cyc = 0; starts = 0; if_acks = 0; d_acks = 0; unstable = 0;
    s_addr = '0; s_size = '0; s_we = 1'b0; s_wdata = '0;
    bus.mm_done = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      bus.mm_done = 1'b0;
      if (bus.if_ack) if_acks++;
      if (bus.d_ack) d_acks++;
      if (bus.if_ack || bus.d_ack) begin
        ack_cyc = k + 1;
        break;
      end
      if (bus.mm_start) begin
        starts++;
        s_addr = bus.mm_addr; s_size = bus.mm_size; s_we = bus.mm_we; s_wdata = bus.mm_wdata;
        in_wait = 1; wc = 0;
        if (drop) begin
          bus.if_req = 1'b0;
          bus.d_req  = 1'b0;
        end
      end else if (in_wait) begin
        wc++;
        if (bus.mm_addr !== s_addr || bus.mm_size !== s_size || bus.mm_we !== s_we ||
            bus.mm_wdata !== s_wdata) unstable = 1;
        if (mutate && wc == 1) begin
          bus.d_addr  = 64'h0;
          bus.d_wdata = 64'hFF;
          bus.d_size  = 2'b11;
        end
        if (wc == n_wait) begin
          bus.mm_done  = 1'b1;
          bus.mm_rdata = rd;
        end
      end
    end
  endtask

  initial begin
    int ack_cyc, starts, if_acks, d_acks, acks, busy_seen;
    logic [63:0] s_addr, s_wdata;
    logic [1:0] s_size;
    logic s_we;
    bit unstable, found, exp_if;

    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_size = 0; bus.d_wdata = 0; bus.mm_done = 0; bus.mm_rdata = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", bus.mm_start, 0);
    check_eq("rst_addr", bus.mm_addr, 0);
    check_eq("rst_acks", {bus.if_ack, bus.d_ack}, 0);
    check_eq("rst_rdata", bus.d_rdata | bus.if_rdata, 0);
    check_eq("rst_timeout", timeout_err, 0);
    reset = 1'b0;

    // 1: single D load, done in 9th WAIT cycle -> ack in cycle 12
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h100; bus.d_size = 2'b11;
    run_xfer(9, 64'h1122334455667788, 0, 0, ack_cyc, starts, if_acks, d_acks,
             s_addr, s_size, s_we, s_wdata, unstable);
    bus.d_req = 0;
    check_eq("t1_ack_cycle", ack_cyc, 12);
    check_eq("t1_starts", starts, 1);
    check_eq("t1_d_ack", d_acks, 1);
    check_eq("t1_if_ack", if_acks, 0);
    check_eq("t1_addr", s_addr, 64'h100);
    check_eq("t1_size", s_size, 2'b11);
    check_eq("t1_we", s_we, 0);
    check_eq("t1_stable", unstable, 0);
    check_eq("t1_rdata", bus.d_rdata, 64'h1122334455667788);
    check_eq("t1_busy_resp", busy, 1);
    @(negedge clk);
    check_eq("t1_ack_pulse", bus.d_ack, 0);
    check_eq("t1_idle", busy, 0);

    // 2: both requesting out of reset -> IF first, then strict alternation
    reset = 1'b1;
    bus.if_req = 1; bus.if_addr = 64'h1000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h2000; bus.d_size = 2'b01; bus.d_wdata = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      exp_if = (r % 2 == 0);
      run_xfer(2, 64'h100 + 64'(r), 0, 0, ack_cyc, starts, if_acks, d_acks,
               s_addr, s_size, s_we, s_wdata, unstable);
      check_eq($sformatf("t2_r%0d_ack_cycle", r), ack_cyc, (r == 0) ? 5 : 6);
      check_eq($sformatf("t2_r%0d_if_ack", r), if_acks, exp_if ? 1 : 0);
      check_eq($sformatf("t2_r%0d_d_ack", r), d_acks, exp_if ? 0 : 1);
      check_eq($sformatf("t2_r%0d_addr", r), s_addr, exp_if ? 64'h1000 : 64'h2000);
      check_eq($sformatf("t2_r%0d_size", r), s_size, exp_if ? 2'b10 : 2'b01);
      check_eq($sformatf("t2_r%0d_we", r), s_we, 0);
    end
    bus.if_req = 0; bus.d_req = 0;
    check_eq("t2_if_rdata", bus.if_rdata, 64'h102);
    check_eq("t2_d_rdata", bus.d_rdata, 64'h103);
    @(negedge clk);

    // 3: store; requester inputs changed during WAIT must not leak through
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h200; bus.d_size = 2'b00; bus.d_wdata = 64'hA5;
    run_xfer(3, 64'hDEAD, 1, 0, ack_cyc, starts, if_acks, d_acks,
             s_addr, s_size, s_we, s_wdata, unstable);
    bus.d_req = 0;
    check_eq("t3_we", s_we, 1);
    check_eq("t3_addr", s_addr, 64'h200);
    check_eq("t3_wdata", s_wdata, 64'hA5);
    check_eq("t3_size", s_size, 2'b00);
    check_eq("t3_stable", unstable, 0);
    check_eq("t3_d_ack", d_acks, 1);
    check_eq("t3_rdata_kept", bus.d_rdata, 64'h103);
    @(negedge clk);

    // 4: watchdog on an IF fetch that never completes
    check_eq("t4_timeout_pre", timeout_err, 0);
    bus.if_req = 1; bus.if_addr = 64'h40;
    run_xfer(0, 64'h0, 0, 0, ack_cyc, starts, if_acks, d_acks,
             s_addr, s_size, s_we, s_wdata, unstable);
    bus.if_req = 0;
    check_eq("t4_ack_cycle", ack_cyc, 67);
    check_eq("t4_if_ack", if_acks, 1);
    check_eq("t4_timeout", timeout_err, 1);
    check_eq("t4_if_rdata", bus.if_rdata, 0);
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h300; bus.d_size = 2'b10;
    run_xfer(3, 64'hDEADBEEF, 0, 0, ack_cyc, starts, if_acks, d_acks,
             s_addr, s_size, s_we, s_wdata, unstable);
    check_eq("t4_next_d_ack", d_acks, 1);
    check_eq("t4_next_rdata", bus.d_rdata, 64'hDEADBEEF);
    check_eq("t4_sticky", timeout_err, 1);
    bus.d_req = 0;
    @(negedge clk);

    // 5: async reset during WAIT
    bus.d_req = 1; bus.d_addr = 64'h400; bus.d_size = 2'b11;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.mm_start) found = 1;
    end
    check_eq("t5_start_seen", found, 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_addr", bus.mm_addr, 0);
    check_eq("t5_size", bus.mm_size, 0);
    check_eq("t5_timeout", timeout_err, 0);
    check_eq("t5_rdata", bus.d_rdata | bus.if_rdata, 0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) acks++;
    end
    check_eq("t5_no_ack", acks, 0);
    reset = 1'b0;
    run_xfer(1, 64'h55, 0, 0, ack_cyc, starts, if_acks, d_acks,
             s_addr, s_size, s_we, s_wdata, unstable);
    bus.d_req = 0;
    check_eq("t5_ack_cycle", ack_cyc, 4);
    check_eq("t5_d_ack", d_acks, 1);
    check_eq("t5_new_rdata", bus.d_rdata, 64'h55);
    @(negedge clk);

    // 6: stray mm_done in IDLE, then a request dropped right after grant
    bus.mm_done = 1;
    acks = 0; busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) acks++;
      if (busy) busy_seen++;
    end
    bus.mm_done = 0;
    check_eq("t6_stray_ack", acks, 0);
    check_eq("t6_stray_busy", busy_seen, 0);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h500; bus.d_size = 2'b10;
    run_xfer(2, 64'h77, 0, 1, ack_cyc, starts, if_acks, d_acks,
             s_addr, s_size, s_we, s_wdata, unstable);
    check_eq("t6_d_ack", d_acks, 1);
    check_eq("t6_rdata", bus.d_rdata, 64'h77);
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) acks++;
    end
    check_eq("t6_single_ack", acks, 0);
    check_eq("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
